// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, flag
// bit positions, instruction field helpers and the sequencer state type.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NAND = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_ROL  = 4'hB;
   localparam logic [3:0] OP_ROR  = 4'hC;
   localparam logic [3:0] OP_PASS = 4'hD;
   localparam logic [3:0] OP_EQ   = 4'hE;
   localparam logic [3:0] OP_LT   = 4'hF;

   localparam int unsigned FLG_CARRY  = 0;
   localparam int unsigned FLG_SIGN   = 1;
   localparam int unsigned FLG_ZERO   = 2;
   localparam int unsigned FLG_PARITY = 3;

   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } seq_state_t;

   function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] i);
      return i[15:12];
   endfunction

   function automatic logic [3:0] instr_rd(input logic [INSTR_W-1:0] i);
      return i[11:8];
   endfunction

   function automatic logic [3:0] instr_rs1(input logic [INSTR_W-1:0] i);
      return i[7:4];
   endfunction

   function automatic logic [3:0] instr_rs2(input logic [INSTR_W-1:0] i);
      return i[3:0];
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the sequencer: two combinational read ports, one
// writeback port and one host load port. R0 always reads zero.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_CNT = 16,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] regs [REG_CNT];

   // Combinational reads; index 0 is forced to zero
   always_comb begin
      rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
      rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
   end

   // Writes with writeback taking priority over the host load; R0 never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < REG_CNT; i++) begin
            if (wb_en && wb_addr == ADDR_W'(i))
               regs[i] <= wb_data;
            else if (ld_en && ld_addr == ADDR_W'(i))
               regs[i] <= ld_data;
         end
      end
   end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of a combinational ALU. Accepts one
// instruction at a time, drives the ALU from latched operands, captures the
// result and flags, writes the result back and offers it downstream.
module alu_issue_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_CNT = 16,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               ld_en,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   output logic [DATA_W-1:0]  alu_in1,
   output logic [DATA_W-1:0]  alu_in2,
   output logic [3:0]         alu_opcode,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic [3:0]         alu_flags,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic [ADDR_W-1:0]  res_rd,
   output logic [3:0]         flags_q
);

   seq_state_t        state;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_a;
   logic [ADDR_W-1:0] rs2_a;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;
   logic [DATA_W-1:0] op1_nxt;
   logic [DATA_W-1:0] op2_nxt;
   logic              wb_first;
   logic              wb_en;

   assign rs1_a       = ADDR_W'(instr_rs1(instr));
   assign rs2_a       = ADDR_W'(instr_rs2(instr));
   assign instr_ready = (state == IDLE);
   assign wb_en       = (state == WB) && wb_first;

   alu_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .ADDR_W  (ADDR_W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rs1_a),
      .rd_data_a (rf_rd1),
      .rd_addr_b (rs2_a),
      .rd_data_b (rf_rd2),
      .wb_en     (wb_en),
      .wb_addr   (res_rd),
      .wb_data   (res_data),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   // Forward a same-cycle host load into the operand it targets (never R0)
   always_comb begin
      op1_nxt = rf_rd1;
      op2_nxt = rf_rd2;
      if (ld_en && ld_addr != '0 && ld_addr == rs1_a) op1_nxt = ld_data;
      if (ld_en && ld_addr != '0 && ld_addr == rs2_a) op2_nxt = ld_data;
   end

   // IDLE -> EXEC -> WB -> IDLE sequencer with registered ALU drive and result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_q       <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_rd     <= '0;
         flags_q    <= '0;
         wb_first   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  alu_opcode <= instr_opcode(instr);
                  rd_q       <= ADDR_W'(instr_rd(instr));
                  alu_in1    <= op1_nxt;
                  alu_in2    <= op2_nxt;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               res_data  <= alu_result;
               flags_q   <= alu_flags;
               res_rd    <= rd_q;
               res_valid <= 1'b1;
               wb_first  <= 1'b1;
               state     <= WB;
            end
            WB: begin
               wb_first <= 1'b0;
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               wb_first  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq with a behavioural ALU attached and an
// architectural register-file model predicting every result.
module tb_alu_issue_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_opcode;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [3:0]  res_rd;
   logic [3:0]  flags_q;

   int errors = 0;
   int checks = 0;
   logic [31:0] ref_rf [16];

   always #5 clk = ~clk;

   alu_issue_seq #(
      .DATA_W  (32),
      .REG_CNT (16),
      .ADDR_W  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_opcode  (alu_opcode),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .flags_q     (flags_q)
   );

   // Behavioural ALU: returns {flags, result}
   function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y;
      logic [63:0] w;
      logic [32:0] s;
      logic [3:0]  f;
      int unsigned sh;
      sh = int'(b[4:0]);
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOT:  y = ~a;
         OP_SHL:  y = a << sh;
         OP_SHR:  y = a >> sh;
         OP_SRA:  y = $signed(a) >>> sh;
         OP_MUL:  y = a * b;
         OP_ROL:  begin w = {a, a} << sh; y = w[63:32]; end
         OP_ROR:  begin w = {a, a} >> sh; y = w[31:0]; end
         OP_PASS: y = a;
         OP_EQ:   y = (a == b) ? 32'd1 : 32'd0;
         default: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      s = {1'b0, a} + {1'b0, b};
      f[FLG_CARRY]  = s[32];
      f[FLG_SIGN]   = y[31];
      f[FLG_ZERO]   = (y == 32'd0);
      f[FLG_PARITY] = ~^y;
      return {f, y};
   endfunction

   always_comb {alu_flags, alu_result} = alu_fn(alu_opcode, alu_in1, alu_in2);

   // Architectural effect of one instruction.
   // ph: 0 no side load, 1 load with accept, 2 load in first WB cycle, 3 load in a later WB cycle
   task automatic model_exec(input logic [15:0] ins, input int ph, input logic [3:0] la,
                             input logic [31:0] ldd, output logic [31:0] ed, output logic [3:0] ef);
      logic [3:0]  op, rd, r1, r2;
      logic [35:0] res;
      op = ins[15:12]; rd = ins[11:8]; r1 = ins[7:4]; r2 = ins[3:0];
      if (ph == 1 && la != 4'd0) ref_rf[la] = ldd;
      res = alu_fn(op, ref_rf[r1], ref_rf[r2]);
      ed = res[31:0];
      ef = res[35:32];
      if (ph == 2 && la != 4'd0 && la != rd) ref_rf[la] = ldd;
      if (rd != 4'd0) ref_rf[rd] = ed;
      if (ph == 3 && la != 4'd0) ref_rf[la] = ldd;
   endtask

   task automatic do_load(input logic [3:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); @(negedge clk);
      ld_en = 1'b0;
      if (a != 4'd0) ref_rf[a] = d;
   endtask

   // Drives one instruction through the sequencer and reports what was observed
   task automatic issue(input logic [15:0] ins, input int hold, input int ph, input logic [3:0] la,
                        input logic [31:0] ldd, output int lat, output logic [31:0] d,
                        output logic [3:0] r, output logic [3:0] fl, output int unstable);
      int w;
      w = 0;
      while (!instr_ready && w < 20) begin @(posedge clk); @(negedge clk); w++; end
      instr = ins; instr_valid = 1'b1; res_ready = 1'b0;
      if (ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
      @(posedge clk); @(negedge clk);
      instr_valid = 1'b0; ld_en = 1'b0;
      lat = 0;
      while (!res_valid && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
      d = res_data; r = res_rd; fl = flags_q; unstable = 0;
      if (ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
      for (int i = 0; i < hold; i++) begin
         if (ph == 3 && i == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
         @(posedge clk); @(negedge clk);
         ld_en = 1'b0;
         if (res_valid !== 1'b1 || res_data !== d || res_rd !== r || instr_ready !== 1'b0) unstable++;
      end
      res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready = 1'b0; ld_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready: got %b expected 1", instr_ready); end
      checks++; if (res_data !== 32'd0 || res_rd !== 4'd0 || flags_q !== 4'd0) begin
         errors++; $display("FAIL reset_result_regs: got data=%h rd=%h flags=%b expected all 0", res_data, res_rd, flags_q); end
      checks++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_opcode !== 4'd0) begin
         errors++; $display("FAIL reset_alu_drive: got in1=%h in2=%h op=%h expected all 0", alu_in1, alu_in2, alu_opcode); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", instr_ready, res_valid); end
   endtask

   task automatic test_add();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      do_load(4'd1, 32'd5);
      do_load(4'd2, 32'd7);
      issue(16'h0312, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0312, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
      checks++; if (d !== 32'd12) begin errors++; $display("FAIL add_data: got %h expected 0000000c", d); end
      checks++; if (r !== 4'd3) begin errors++; $display("FAIL add_rd: got %h expected 3", r); end
      checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL add_flags: got %b expected 1000", fl); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready_after: got %b expected 1", instr_ready); end
      issue(16'h0030, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0030, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd12) begin errors++; $display("FAIL add_readback_r3: got %h expected 0000000c", d); end
   endtask

   task automatic test_carry_zero();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      do_load(4'd1, 32'hFFFF_FFFF);
      do_load(4'd2, 32'd1);
      issue(16'h0512, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0512, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL carry_data: got %h expected 00000000", d); end
      checks++; if (fl !== 4'b1101) begin errors++; $display("FAIL carry_flags: got %b expected 1101", fl); end
   endtask

   task automatic test_backpressure();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      do_load(4'd1, 32'd100);
      do_load(4'd2, 32'd23);
      issue(16'h0312, 5, 3, 4'd3, 32'hDEAD_BEEF, lat, d, r, fl, un);
      model_exec(16'h0312, 3, 4'd3, 32'hDEAD_BEEF, ed, ef);
      checks++; if (un !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", un); end
      checks++; if (d !== 32'd123) begin errors++; $display("FAIL bp_data: got %h expected 0000007b", d); end
      checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", instr_ready, res_valid); end
      issue(16'h0030, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0030, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_single_write: got %h expected deadbeef", d); end
   endtask

   task automatic test_r0_collision();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      issue(16'h3012, 1, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h3012, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd119 || r !== 4'd0) begin
         errors++; $display("FAIL r0_result: got data=%h rd=%h expected 00000077/0", d, r); end
      issue(16'h0000, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0000, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL r0_reads_zero: got %h expected 00000000", d); end
      issue(16'h0312, 2, 2, 4'd3, 32'h0000_1111, lat, d, r, fl, un);
      model_exec(16'h0312, 2, 4'd3, 32'h0000_1111, ed, ef);
      issue(16'h0030, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0030, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd123) begin errors++; $display("FAIL wb_beats_ld: got %h expected 0000007b", d); end
   endtask

   task automatic test_forward();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      issue(16'h6540, 0, 1, 4'd4, 32'hA5A5_A5A5, lat, d, r, fl, un);
      model_exec(16'h6540, 1, 4'd4, 32'hA5A5_A5A5, ed, ef);
      checks++; if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL fwd_not: got %h expected 5a5a5a5a", d); end
      issue(16'h0744, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0744, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'h4B4B_4B4A) begin errors++; $display("FAIL same_src: got %h expected 4b4b4b4a", d); end
   endtask

   task automatic test_back_to_back();
      int acc; logic [31:0] ed; logic [3:0] ef;
      acc = 0;
      instr = 16'h0512; instr_valid = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (instr_ready) begin acc++; model_exec(16'h0512, 0, 4'd0, 32'd0, ed, ef); end
         if (i == 11) instr_valid = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      res_ready = 1'b0;
      checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc); end
      checks++; if (res_data !== ed) begin errors++; $display("FAIL b2b_data: got %h expected %h", res_data, ed); end
   endtask

   task automatic test_reset_exec();
      int lat, un; logic [31:0] d, ed; logic [3:0] r, fl, ef;
      instr = 16'h0612; instr_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
         errors++; $display("FAIL rst_exec_ctrl: got valid=%b ready=%b expected 0/1", res_valid, instr_ready); end
      checks++; if (alu_in1 !== 32'd0 || res_data !== 32'd0 || flags_q !== 4'd0) begin
         errors++; $display("FAIL rst_exec_regs: got in1=%h data=%h flags=%b expected 0", alu_in1, res_data, flags_q); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) ref_rf[i] = 32'd0;
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready: got %b expected 1", instr_ready); end
      issue(16'h0010, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0010, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_rf_cleared: got %h expected 00000000", d); end
      issue(16'h0060, 0, 0, 4'd0, 32'd0, lat, d, r, fl, un);
      model_exec(16'h0060, 0, 4'd0, 32'd0, ed, ef);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_rd_not_written: got %h expected 00000000", d); end
   endtask

   task automatic test_random();
      int lat, un, hold, ph; logic [31:0] d, ed; logic [3:0] r, fl, ef, la; logic [15:0] ins;
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            do_load(4'($urandom_range(0, 15)), $urandom);
         ins  = 16'($urandom);
         hold = int'($urandom_range(0, 3));
         ph   = int'($urandom_range(0, 3));
         if (ph == 3 && hold < 2) ph = 0;
         la   = 4'($urandom_range(0, 15));
         ld_data = $urandom;
         issue(ins, hold, ph, la, ld_data, lat, d, r, fl, un);
         model_exec(ins, ph, la, ld_data, ed, ef);
         checks++; if (lat !== 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected 1", n, lat); end
         checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data[%0d] ins=%h: got %h expected %h", n, ins, d, ed); end
         checks++; if (r !== ins[11:8]) begin errors++; $display("FAIL rnd_rd[%0d]: got %h expected %h", n, r, ins[11:8]); end
         checks++; if (fl !== ef) begin errors++; $display("FAIL rnd_flags[%0d] ins=%h: got %b expected %b", n, ins, fl, ef); end
         checks++; if (un !== 0) begin errors++; $display("FAIL rnd_stable[%0d]: got %0d unstable expected 0", n, un); end
      end
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
      ld_addr = '0; ld_data = '0; res_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_rf[i] = 32'd0;
      @(negedge clk);
      test_reset();
      test_add();
      test_carry_zero();
      test_backpressure();
      test_r0_collision();
      test_forward();
      test_back_to_back();
      test_reset_exec();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
